// File: rtl/uart_tx_if.sv
// uart_tx_if: pop handshake between the TX FIFO and the UART serializer.
interface uart_tx_if #(
    parameter int DataLength = 8
);
    logic [DataLength-1:0] i_tx_data;
    logic i_tx_fifo_empty;
    logic o_tx_fifo_read_en;
    modport master (input i_tx_data, input i_tx_fifo_empty, output o_tx_fifo_read_en);
    modport slave (output i_tx_data, output i_tx_fifo_empty, input o_tx_fifo_read_en);
endinterface

// File: rtl/uart_tx.sv
// uart_tx: pops words from a TX FIFO and serializes them as start/data/optional parity/stop frames.
module uart_tx #(
    parameter int SystemClockFreq = 50_000_000,
    parameter int BaudRate = 115200,
    parameter bit Parity = 1'b0,
    parameter bit ParityEven = 1'b0,
    parameter int DataLength = 8
) (
    input logic i_clk,
    input logic i_rst,
    uart_tx_if.master fifo,
    output logic o_tx,
    output logic o_busy
);
    localparam int CyclesPerBit = SystemClockFreq / BaudRate;
    localparam int CntW = CyclesPerBit > 1 ? $clog2(CyclesPerBit) : 1;
    localparam int BitW = DataLength > 1 ? $clog2(DataLength) : 1;
    typedef enum logic [2:0] {IDLE, FETCH, START, DATA, PARITY, STOP} state_t;
    state_t state, next_state;
    logic [CntW-1:0] cnt, cnt_d;
    logic [BitW-1:0] bit_cnt, bit_cnt_d;
    logic [DataLength-1:0] shift, shift_d;
    logic par, par_d, tx_d, wrap, load;
    assign wrap = cnt == CntW'(CyclesPerBit - 1);
    assign load = state == START && cnt == '0;
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else state <= next_state;
    end
    always_comb begin
        next_state = state;
        case (state)
            IDLE: next_state = fifo.i_tx_fifo_empty ? IDLE : FETCH;
            FETCH: next_state = START;
            START: next_state = wrap ? DATA : START;
            DATA: next_state = !(wrap && bit_cnt == '0) ? DATA : Parity ? PARITY : STOP;
            PARITY: next_state = wrap ? STOP : PARITY;
            STOP: next_state = wrap ? IDLE : STOP;
            default: next_state = IDLE;
        endcase
    end
    // The word is captured one cycle after the pop, when the FIFO output is valid.
    always_comb begin
        cnt_d = (next_state != state || wrap || state == IDLE || state == FETCH) ? '0 : cnt + 1'b1;
        shift_d = load ? fifo.i_tx_data : (state == DATA && wrap) ? shift >> 1 : shift;
        par_d = load ? (ParityEven ? ^fifo.i_tx_data : ~^fifo.i_tx_data) : par;
        bit_cnt_d = (next_state == DATA && state != DATA) ? BitW'(DataLength - 1) :
                    (state == DATA && wrap && bit_cnt != '0) ? bit_cnt - 1'b1 : bit_cnt;
    end
    // Line value is chosen from the next state so the registered o_tx lines up with the state.
    always_comb begin
        tx_d = next_state == START ? 1'b0 :
               next_state == DATA ? shift_d[0] :
               next_state == PARITY ? par : 1'b1;
        o_busy = state != IDLE;
        fifo.o_tx_fifo_read_en = state == FETCH;
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt <= '0;
            bit_cnt <= '0;
            shift <= '0;
            par <= 1'b0;
            o_tx <= 1'b1;
        end else begin
            cnt <= cnt_d;
            bit_cnt <= bit_cnt_d;
            shift <= shift_d;
            par <= par_d;
            o_tx <= tx_d;
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed checks of uart_tx in no-parity, even-parity and odd-parity builds.
module tb_uart_tx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic empty [3];
    logic [7:0] data [3];
    logic rd [3];
    logic tx [3];
    logic busy [3];
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : u
        uart_tx_if #(.DataLength(8)) bus ();
        assign bus.i_tx_data = data[g];
        assign bus.i_tx_fifo_empty = empty[g];
        assign rd[g] = bus.o_tx_fifo_read_en;
        uart_tx #(
            .SystemClockFreq(160), .BaudRate(10),
            .Parity(g > 0), .ParityEven(g == 1), .DataLength(8)
        ) dut (
            .i_clk(clk), .i_rst(rst), .fifo(bus.master), .o_tx(tx[g]), .o_busy(busy[g])
        );
    end

    // Expected line at cycle i after the FETCH cycle (i = 0); 16 clocks per bit.
    function automatic logic exp_line(input int i, input logic [7:0] w, input int k, input logic pbit);
        int p;
        if (i <= 0) return 1'b1;
        p = (i - 1) / 16;
        if (p == 0) return 1'b0;
        if (p <= 8) return w[p-1];
        if (p == 9 && k > 0) return pbit;
        return 1'b1;
    endfunction

    task automatic run_frame(input int k, input logic [7:0] w, input logic pbit, input bit scramble, input string name);
        int nbits = k > 0 ? 11 : 10;
        int nbusy = 0;
        int nrd = 0;
        logic bad, seen;
        @(negedge clk);
        data[k] = w;
        empty[k] = 1'b0;
        @(negedge clk);
        vectors++;
        if (rd[k] !== 1'b1 || tx[k] !== 1'b1) begin
            miscompares++;
            $display("FAIL %s fetch: read_en=%b tx=%b, need 1 1", name, rd[k], tx[k]);
        end
        if (busy[k] === 1'b1) nbusy++;
        if (rd[k] === 1'b1) nrd++;
        empty[k] = 1'b1;
        for (int b = 0; b < nbits; b++) begin
            bad = 1'b0;
            seen = 1'b0;
            for (int c = 0; c < 16; c++) begin
                @(negedge clk);
                if (scramble && (b > 0 || c > 0)) data[k] = 8'($urandom);
                if (tx[k] !== exp_line(1 + 16 * b + c, w, k, pbit)) begin
                    bad = 1'b1;
                    seen = tx[k];
                end
                if (busy[k] === 1'b1) nbusy++;
                if (rd[k] === 1'b1) nrd++;
            end
            vectors++;
            if (bad) begin
                miscompares++;
                $display("FAIL %s bit %0d: line=%b, need %b", name, b, seen, exp_line(1 + 16 * b, w, k, pbit));
            end
        end
        @(negedge clk);
        vectors++;
        if (tx[k] !== 1'b1 || busy[k] !== 1'b0) begin
            miscompares++;
            $display("FAIL %s idle after frame: tx=%b busy=%b, need 1 0", name, tx[k], busy[k]);
        end
        vectors++;
        if (nbusy != 1 + 16 * nbits) begin
            miscompares++;
            $display("FAIL %s busy length: %0d clocks, need %0d", name, nbusy, 1 + 16 * nbits);
        end
        vectors++;
        if (nrd != 1) begin
            miscompares++;
            $display("FAIL %s read_en pulses: %0d, need 1", name, nrd);
        end
    endtask

    task automatic test_reset();
        int bad = 0;
        empty[0] = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (rd[0] !== 1'b0 || busy[0] !== 1'b0) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL reset_hold: %0d cycles active under reset, need 0", bad);
        end
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (tx[k] !== 1'b1 || busy[k] !== 1'b0 || rd[k] !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_state[%0d]: tx=%b busy=%b read_en=%b, need 1 0 0", k, tx[k], busy[k], rd[k]);
            end
        end
        empty[0] = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_idle();
        int bad [3] = '{0, 0, 0};
        repeat (1000) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++)
                if (tx[k] !== 1'b1 || busy[k] !== 1'b0 || rd[k] !== 1'b0) bad[k]++;
        end
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (bad[k] != 0) begin
                miscompares++;
                $display("FAIL idle_empty[%0d]: %0d active cycles, need 0", k, bad[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic line [330];
        logic rdv [330];
        int nrd = 0;
        logic [7:0] w;
        logic e;
        @(negedge clk);
        data[0] = 8'h55;
        empty[0] = 1'b0;
        for (int i = 0; i < 330; i++) begin
            @(negedge clk);
            line[i] = tx[0];
            rdv[i] = rd[0];
            if (rd[0] === 1'b1) nrd++;
            if (nrd == 2) empty[0] = 1'b1;
            if (i == 2) data[0] = 8'hFF;
        end
        vectors++;
        if (nrd != 2) begin
            miscompares++;
            $display("FAIL b2b read_en pulses: %0d, need 2", nrd);
        end
        vectors++;
        if (rdv[162] !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b second fetch: read_en=%b at clock 162, need 1", rdv[162]);
        end
        vectors++;
        if (line[160] !== 1'b1 || line[161] !== 1'b1 || line[162] !== 1'b1 || line[163] !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b gap: line=%b%b%b%b, need 1110", line[160], line[161], line[162], line[163]);
        end
        for (int f = 0; f < 2; f++) begin
            w = f == 0 ? 8'h55 : 8'hFF;
            for (int b = 0; b < 10; b++) begin
                e = exp_line(1 + 16 * b + 8, w, 0, 1'b0);
                vectors++;
                if (line[162 * f + 1 + 16 * b + 8] !== e) begin
                    miscompares++;
                    $display("FAIL b2b frame %0d bit %0d: line=%b, need %b", f, b, line[162 * f + 1 + 16 * b + 8], e);
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int bad = 0;
        @(negedge clk);
        data[0] = 8'hA5;
        empty[0] = 1'b0;
        @(negedge clk);
        empty[0] = 1'b1;
        repeat (40) @(negedge clk);
        vectors++;
        if (tx[0] !== 1'b0 || busy[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_before: tx=%b busy=%b, need 0 1", tx[0], busy[0]);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (tx[0] !== 1'b1 || busy[0] !== 1'b0 || rd[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_immediate: tx=%b busy=%b read_en=%b, need 1 0 0", tx[0], busy[0], rd[0]);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (200) begin
            @(negedge clk);
            if (tx[0] !== 1'b1 || busy[0] !== 1'b0 || rd[0] !== 1'b0) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL abort_after: %0d active cycles after release, need 0", bad);
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            empty[k] = 1'b1;
            data[k] = 8'h00;
        end
        test_reset();
        test_idle();
        run_frame(0, 8'hA5, 1'b0, 1'b0, "frame_a5");
        run_frame(1, 8'h07, 1'b1, 1'b0, "even_07");
        run_frame(2, 8'h07, 1'b0, 1'b0, "odd_07");
        run_frame(1, 8'hA5, 1'b0, 1'b0, "even_a5");
        run_frame(2, 8'hA5, 1'b1, 1'b0, "odd_a5");
        run_frame(0, 8'h3C, 1'b0, 1'b1, "data_hold_3c");
        test_back_to_back();
        test_reset_mid_frame();
        run_frame(0, 8'h81, 1'b0, 1'b0, "post_reset_81");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter SystemClockFreq, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BaudRate, default 115200, line bit rate.
REQ-003 SHALL have parameter Parity, default 1'b0, 1 = insert parity bit after data.
REQ-004 SHALL have parameter ParityEven, default 1'b0, 1 = even parity, 0 = odd parity.
REQ-005 SHALL have parameter DataLength, default 8, data bits per frame.
REQ-006 SHALL have port i_clk  input  1  single clock; all logic rising-edge.
REQ-007 SHALL have port i_rst  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port i_tx_data  input  DataLength  word from TX FIFO, valid the cycle after a read strobe.
REQ-009 SHALL have port i_tx_fifo_empty  input  1  high when the TX FIFO holds no word.
REQ-010 SHALL have port o_tx_fifo_read_en  output  1  one-cycle pop strobe to TX FIFO.
REQ-011 SHALL have port o_tx  output  1  serial line, idle high.
REQ-012 SHALL have port o_busy  output  1  high while a frame is being fetched or sent.

Function
REQ-013 SHALL define CyclesPerBit = SystemClockFreq / BaudRate (integer divide); each line bit SHALL last exactly CyclesPerBit clocks.
REQ-014 SHALL implement FSM states IDLE, FETCH, START, DATA, PARITY, STOP.
REQ-015 IDLE: o_tx = 1; if i_tx_fifo_empty = 0, go to FETCH; else stay.
REQ-016 FETCH (exactly one cycle): o_tx_fifo_read_en = 1; next state LOAD-capture cycle is START entry.
REQ-017 On the first cycle of START, i_tx_data SHALL be latched into the shift register and the parity bit computed from it; later i_tx_data changes SHALL have no effect on the frame.
REQ-018 o_tx_fifo_read_en SHALL be high only in FETCH, never two consecutive cycles, never while i_tx_fifo_empty = 1 was sampled in IDLE.
REQ-019 START: o_tx = 0 for CyclesPerBit clocks, then DATA.
REQ-020 DATA: send DataLength bits LSB first, one bit per CyclesPerBit clocks; bit counter counts DataLength-1 down to 0; after bit 0-count expires go to PARITY if Parity = 1, else STOP.
REQ-021 PARITY: o_tx = XOR of data bits if ParityEven = 1, inverted XOR if ParityEven = 0, for CyclesPerBit clocks, then STOP.
REQ-022 STOP: o_tx = 1 for CyclesPerBit clocks, then IDLE.
REQ-023 Clock counter SHALL count 0 to CyclesPerBit-1, wrap to 0, and be cleared on every state transition into START, DATA, PARITY, STOP.
REQ-024 o_tx SHALL be registered (glitch-free); transitions occur only on bit boundaries.
REQ-025 o_busy SHALL be 0 in IDLE and 1 in all other states.
REQ-026 Back-to-back: with FIFO non-empty at STOP end, the line SHALL stay high exactly 2 clocks (IDLE, FETCH) between stop bit end and next start bit.
REQ-027 i_tx_fifo_empty rising during a frame SHALL not affect the frame in progress.

Reset
REQ-028 i_rst high SHALL immediately force: state IDLE, o_tx = 1, o_busy = 0, o_tx_fifo_read_en = 0, counters = 0, shift register = 0.
REQ-029 Reset asserted mid-frame SHALL abort the frame; the line returns high with no further bits; the popped word is discarded.
REQ-030 After reset release, the first frame SHALL start only after IDLE samples i_tx_fifo_empty = 0.

Verification (SystemClockFreq = 160, BaudRate = 10, CyclesPerBit = 16)
REQ-031 Parity = 0, FIFO presents 8'hA5 once -> one read_en pulse; o_tx: 16 low, bits 1,0,1,0,0,1,0,1 at 16 clocks each, 16 high; o_busy high 161 clocks total.
REQ-032 Parity = 1, ParityEven = 1, data 8'h07 -> parity bit 1; ParityEven = 0, data 8'h07 -> parity bit 0; frame 176 clocks + FETCH.
REQ-033 FIFO holds 8'h55 then 8'hFF -> two frames, exactly 2 high idle clocks between first stop end and second start; two read_en pulses total.
REQ-034 i_tx_fifo_empty held 1 for 1000 clocks -> o_tx = 1, o_busy = 0, read_en never asserted.
REQ-035 Assert i_rst at clock 40 of a frame (mid DATA) -> o_tx = 1 and o_busy = 0 in same cycle; after release with FIFO empty, line stays high.
REQ-036 Change i_tx_data every clock during a frame of 8'h3C -> serialized bits still 0,0,1,1,1,1,0,0.
